// File: rtl/id_operand_fetch.sv
// rtl/id_operand_fetch.sv - register file read, operand bypass, load-use stall and ID/EX register
module id_operand_fetch #(
    parameter int DW  = 32,
    parameter int AW  = 5,
    parameter int SCW = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           id_valid,
    input  logic [AW-1:0]  id_rs,
    input  logic [AW-1:0]  id_rt,
    input  logic           id_rs_used,
    input  logic           id_rt_used,
    input  logic [AW-1:0]  id_wd,
    input  logic           id_wreg,
    output logic           re1,
    output logic [AW-1:0]  raddr1,
    input  logic [DW-1:0]  rdata1,
    output logic           re2,
    output logic [AW-1:0]  raddr2,
    input  logic [DW-1:0]  rdata2,
    input  logic           ex_we,
    input  logic [AW-1:0]  ex_waddr,
    input  logic [DW-1:0]  ex_wdata,
    input  logic           ex_is_load,
    input  logic           mem_we,
    input  logic [AW-1:0]  mem_waddr,
    input  logic [DW-1:0]  mem_wdata,
    input  logic           wb_we,
    input  logic [AW-1:0]  wb_waddr,
    input  logic [DW-1:0]  wb_wdata,
    input  logic           stall_in,
    input  logic           flush,
    output logic           stall_req,
    output logic           ex_valid,
    output logic [DW-1:0]  ex_reg1,
    output logic [DW-1:0]  ex_reg2,
    output logic [AW-1:0]  ex_wd,
    output logic           ex_wreg,
    output logic [SCW-1:0] stall_cnt
);

    logic [DW-1:0] op1;
    logic [DW-1:0] op2;
    logic          lu;

    // Youngest producer wins; a load in EX has no data yet, so it is skipped here
    // and caught by the load-use stall instead.
    function automatic logic [DW-1:0] resolve(
        input logic          used,
        input logic [AW-1:0] addr,
        input logic [DW-1:0] rdata,
        input logic          e_we,
        input logic [AW-1:0] e_addr,
        input logic [DW-1:0] e_data,
        input logic          e_load,
        input logic          m_we,
        input logic [AW-1:0] m_addr,
        input logic [DW-1:0] m_data,
        input logic          w_we,
        input logic [AW-1:0] w_addr,
        input logic [DW-1:0] w_data
    );
        if (!used || addr == '0)
            return '0;
        else if (e_we && e_addr == addr && !e_load)
            return e_data;
        else if (m_we && m_addr == addr)
            return m_data;
        else if (w_we && w_addr == addr)
            return w_data;
        else
            return rdata;
    endfunction

    assign re1    = id_valid & id_rs_used;
    assign raddr1 = id_rs;
    assign re2    = id_valid & id_rt_used;
    assign raddr2 = id_rt;

    always_comb begin
        op1 = resolve(id_rs_used, id_rs, rdata1, ex_we, ex_waddr, ex_wdata, ex_is_load,
                      mem_we, mem_waddr, mem_wdata, wb_we, wb_waddr, wb_wdata);
        op2 = resolve(id_rt_used, id_rt, rdata2, ex_we, ex_waddr, ex_wdata, ex_is_load,
                      mem_we, mem_waddr, mem_wdata, wb_we, wb_waddr, wb_wdata);
    end

    assign lu = id_valid & ex_we & ex_is_load & (ex_waddr != '0) &
                ((id_rs_used & (id_rs == ex_waddr)) | (id_rt_used & (id_rt == ex_waddr)));
    assign stall_req = lu & ~flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid  <= 1'b0;
            ex_reg1   <= '0;
            ex_reg2   <= '0;
            ex_wd     <= '0;
            ex_wreg   <= 1'b0;
            stall_cnt <= '0;
        end else begin
            if (stall_req && !stall_in && !(&stall_cnt))
                stall_cnt <= stall_cnt + 1'b1;

            // A held EX stage cannot accept a bubble, so stall_in outranks lu.
            if (flush || (!stall_in && lu)) begin
                ex_valid <= 1'b0;
                ex_reg1  <= '0;
                ex_reg2  <= '0;
                ex_wd    <= '0;
                ex_wreg  <= 1'b0;
            end else if (!stall_in) begin
                ex_valid <= id_valid;
                ex_reg1  <= op1;
                ex_reg2  <= op2;
                ex_wd    <= id_wd;
                ex_wreg  <= id_valid & id_wreg;
            end
        end
    end

endmodule

// File: tb/tb_id_operand_fetch.sv
// tb/tb_id_operand_fetch.sv - vector table and scoreboard bench for id_operand_fetch
module tb_id_operand_fetch;

    typedef struct packed {
        logic        we;
        logic [4:0]  a;
        logic [31:0] d;
    } fwd_t;

    typedef struct {
        int   rst, si, fl;
        int   val, rs, rt, rsu, rtu, wd, wreg;
        int   rd1, rd2;
        fwd_t ex;
        int   ld;
        fwd_t mem, wb;
        int   ere1, ere2, esr;
        int   ev, er1, er2, ewd, ewreg, ecnt;
    } vec_t;

    typedef struct {
        logic        v;
        logic [31:0] r1, r2;
        logic [4:0]  wd;
        logic        wreg;
        logic [1:0]  cnt;
    } exp_t;

    localparam fwd_t NF = '0;

    function automatic fwd_t f(input int a, input int d);
        fwd_t r;
        r.we = 1'b1;
        r.a  = a[4:0];
        r.d  = d[31:0];
        return r;
    endfunction

    logic        clk = 1'b0;
    logic        rst, id_valid, id_rs_used, id_rt_used, id_wreg;
    logic [4:0]  id_rs, id_rt, id_wd;
    logic        re1, re2;
    logic [4:0]  raddr1, raddr2;
    logic [31:0] rdata1, rdata2;
    logic        ex_we, ex_is_load, mem_we, wb_we;
    logic [4:0]  ex_waddr, mem_waddr, wb_waddr;
    logic [31:0] ex_wdata, mem_wdata, wb_wdata;
    logic        stall_in, flush, stall_req;
    logic        ex_valid, ex_wreg;
    logic [31:0] ex_reg1, ex_reg2;
    logic [4:0]  ex_wd;
    logic [1:0]  stall_cnt;

    always #5 clk = ~clk;

    id_operand_fetch #(.DW(32), .AW(5), .SCW(2)) dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
        .id_wd(id_wd), .id_wreg(id_wreg),
        .re1(re1), .raddr1(raddr1), .rdata1(rdata1),
        .re2(re2), .raddr2(raddr2), .rdata2(rdata2),
        .ex_we(ex_we), .ex_waddr(ex_waddr), .ex_wdata(ex_wdata), .ex_is_load(ex_is_load),
        .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
        .stall_in(stall_in), .flush(flush), .stall_req(stall_req),
        .ex_valid(ex_valid), .ex_reg1(ex_reg1), .ex_reg2(ex_reg2),
        .ex_wd(ex_wd), .ex_wreg(ex_wreg), .stall_cnt(stall_cnt)
    );

    int   n_vec = 0;
    int   n_bad = 0;
    exp_t exp_q[$];
    vec_t tbl[23];

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] req);
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s vec %0d: got %h want %h", name, idx, act, req);
        end
    endtask

    task automatic drive(input vec_t v);
        rst = v.rst[0]; stall_in = v.si[0]; flush = v.fl[0];
        id_valid = v.val[0]; id_rs = v.rs[4:0]; id_rt = v.rt[4:0];
        id_rs_used = v.rsu[0]; id_rt_used = v.rtu[0]; id_wd = v.wd[4:0]; id_wreg = v.wreg[0];
        rdata1 = v.rd1[31:0]; rdata2 = v.rd2[31:0];
        ex_we = v.ex.we; ex_waddr = v.ex.a; ex_wdata = v.ex.d; ex_is_load = v.ld[0];
        mem_we = v.mem.we; mem_waddr = v.mem.a; mem_wdata = v.mem.d;
        wb_we = v.wb.we; wb_waddr = v.wb.a; wb_wdata = v.wb.d;
    endtask

    task automatic check_post(input int idx);
        exp_t e;
        if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL scoreboard vec %0d: got empty queue want entry", idx);
            return;
        end
        e = exp_q.pop_front();
        chk("ex_valid",  idx, {31'b0, ex_valid},  {31'b0, e.v});
        chk("ex_reg1",   idx, ex_reg1,            e.r1);
        chk("ex_reg2",   idx, ex_reg2,            e.r2);
        chk("ex_wd",     idx, {27'b0, ex_wd},     {27'b0, e.wd});
        chk("ex_wreg",   idx, {31'b0, ex_wreg},   {31'b0, e.wreg});
        chk("stall_cnt", idx, {30'b0, stall_cnt}, {30'b0, e.cnt});
    endtask

    initial begin
        //          rst si fl  val rs  rt rsu rtu wd wreg  rd1     rd2      ex                 ld  mem               wb                re1 re2 sr   v  r1      r2       wd wreg cnt
        tbl[0]  = '{1, 0, 0,  0, 0,  0, 0, 0, 0, 0,   'h0,    'h0,     NF,                0,  NF,               NF,               0, 0, 0,   0, 'h0,    'h0,     0, 0, 0};
        tbl[1]  = '{0, 0, 0,  1, 3,  4, 1, 1, 9, 1,   'h11,   'h22,    NF,                0,  NF,               NF,               1, 1, 0,   1, 'h11,   'h22,    9, 1, 0};
        tbl[2]  = '{0, 0, 0,  1, 5,  0, 1, 1, 5, 1,   'h99,   'h0,     f(5, 'hAAAA),      0,  f(5, 'hBBBB),     f(5, 'hCCCC),     1, 1, 0,   1, 'hAAAA, 'h0,     5, 1, 0};
        tbl[3]  = '{0, 0, 0,  1, 5,  0, 1, 1, 5, 1,   'h99,   'h0,     NF,                0,  f(5, 'hBBBB),     f(5, 'hCCCC),     1, 1, 0,   1, 'hBBBB, 'h0,     5, 1, 0};
        tbl[4]  = '{0, 0, 0,  1, 5,  0, 1, 1, 5, 1,   'h99,   'h0,     NF,                0,  NF,               f(5, 'hCCCC),     1, 1, 0,   1, 'hCCCC, 'h0,     5, 1, 0};
        tbl[5]  = '{0, 0, 0,  1, 0,  0, 1, 1, 5, 1,   'h55,   'h66,    f(0, 1),           0,  f(0, 2),          f(0, 3),          1, 1, 0,   1, 'h0,    'h0,     5, 1, 0};
        tbl[6]  = '{0, 0, 0,  1, 3,  6, 1, 1, 6, 1,   'h11,   'h66,    f(6, 'h600D),      0,  NF,               NF,               1, 1, 0,   1, 'h11,   'h600D,  6, 1, 0};
        tbl[7]  = '{0, 0, 0,  1, 3,  7, 1, 1, 8, 1,   'h11,   'h77,    f(7, 'hDEAD),      1,  NF,               NF,               1, 1, 1,   0, 'h0,    'h0,     0, 0, 1};
        tbl[8]  = '{0, 0, 0,  1, 3,  7, 1, 1, 8, 1,   'h11,   'h77,    NF,                0,  f(7, 'h1234),     NF,               1, 1, 0,   1, 'h11,   'h1234,  8, 1, 1};
        tbl[9]  = '{0, 0, 0,  1, 7,  4, 0, 1, 2, 1,   'h77,   'h22,    f(7, 'hDEAD),      1,  NF,               NF,               0, 1, 0,   1, 'h0,    'h22,    2, 1, 1};
        tbl[10] = '{0, 0, 0,  1, 3,  4, 1, 1, 9, 1,   'h11,   'h22,    NF,                0,  NF,               NF,               1, 1, 0,   1, 'h11,   'h22,    9, 1, 1};
        tbl[11] = '{0, 1, 0,  1, 5,  4, 1, 1, 12, 1,  'h77,   'h22,    NF,                0,  NF,               NF,               1, 1, 0,   1, 'h11,   'h22,    9, 1, 1};
        tbl[12] = '{0, 1, 0,  1, 5,  4, 1, 1, 12, 1,  'h77,   'h22,    f(5, 'hDEAD),      1,  NF,               NF,               1, 1, 1,   1, 'h11,   'h22,    9, 1, 1};
        tbl[13] = '{0, 1, 0,  1, 6,  4, 1, 1, 12, 0,  'h88,   'h33,    NF,                0,  NF,               NF,               1, 1, 0,   1, 'h11,   'h22,    9, 1, 1};
        tbl[14] = '{0, 1, 1,  1, 5,  4, 1, 1, 12, 1,  'h77,   'h22,    f(5, 'hDEAD),      1,  NF,               NF,               1, 1, 0,   0, 'h0,    'h0,     0, 0, 1};
        tbl[15] = '{0, 0, 0,  1, 10, 4, 1, 1, 13, 1,  'h0,    'h22,    f(10, 'hDEAD),     1,  NF,               NF,               1, 1, 1,   0, 'h0,    'h0,     0, 0, 2};
        tbl[16] = '{0, 0, 0,  1, 10, 11, 1, 1, 14, 1, 'h0,    'h0,     f(11, 'hBEEF),     1,  f(10, 'hA0),      NF,               1, 1, 1,   0, 'h0,    'h0,     0, 0, 3};
        tbl[17] = '{0, 0, 0,  1, 10, 11, 1, 1, 14, 1, 'h0,    'h0,     NF,                0,  f(11, 'hB0),      f(10, 'hA0),      1, 1, 0,   1, 'hA0,   'hB0,    14, 1, 3};
        tbl[18] = tbl[15]; tbl[18].ecnt = 3;
        tbl[19] = tbl[18];
        tbl[20] = tbl[18];
        tbl[21] = tbl[15]; tbl[21].rst = 1; tbl[21].ecnt = 0;
        tbl[22] = '{0, 0, 0,  0, 7,  4, 1, 1, 3, 1,   'h0,    'h0,     f(7, 'hDEAD),      1,  NF,               NF,               0, 0, 0,   0, 'h0,    'h0,     3, 0, 0};

        foreach (tbl[i]) begin
            exp_t e;
            @(negedge clk);
            drive(tbl[i]);
            e.v = tbl[i].ev[0]; e.r1 = tbl[i].er1[31:0]; e.r2 = tbl[i].er2[31:0];
            e.wd = tbl[i].ewd[4:0]; e.wreg = tbl[i].ewreg[0]; e.cnt = tbl[i].ecnt[1:0];
            exp_q.push_back(e);
            #1;
            n_vec++;
            chk("re1",       i, {31'b0, re1},       tbl[i].ere1[31:0]);
            chk("re2",       i, {31'b0, re2},       tbl[i].ere2[31:0]);
            chk("raddr1",    i, {27'b0, raddr1},    tbl[i].rs[31:0]);
            chk("raddr2",    i, {27'b0, raddr2},    tbl[i].rt[31:0]);
            chk("stall_req", i, {31'b0, stall_req}, tbl[i].esr[31:0]);
            @(posedge clk);
            #1;
            check_post(i);
        end

        // back-to-back hazard-free stream: one result per cycle with unit latency
        for (int k = 0; k < 8; k++) begin
            vec_t v;
            exp_t e;
            @(negedge clk);
            v = tbl[1];
            v.rs = $urandom_range(1, 31); v.rt = $urandom_range(1, 31);
            v.rd1 = $urandom; v.rd2 = $urandom;
            v.wd = $urandom_range(0, 31); v.wreg = $urandom_range(0, 1);
            drive(v);
            e.v = 1'b1; e.r1 = v.rd1[31:0]; e.r2 = v.rd2[31:0];
            e.wd = v.wd[4:0]; e.wreg = v.wreg[0]; e.cnt = 2'd0;
            exp_q.push_back(e);
            n_vec++;
            @(posedge clk);
            #1;
            check_post(100 + k);
        end

        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard drain: got %0d left want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
